// File: rtl/en_pulse_pkg.sv
// Shared types and elaboration helpers for the enable-strobe generator.
// Consumed by en_pulse_gen and btn_debounce.
package en_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } db_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

    // Bits needed for a counter that runs 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer, debounce FSM and press strobe generator.
// Optional hold-to-repeat strobes when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce
    import en_pulse_pkg::*;
#(
    parameter int unsigned DBC  = 4
`ifdef BTN_AUTO_REPEAT_EN
   ,parameter int unsigned RDLY = 20
   ,parameter int unsigned RPER = 10
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic lvl_o,
    output logic en_o
);

    localparam int unsigned DW = cnt_width(DBC);
    localparam logic [DW-1:0] DLAST = DW'(DBC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          s_q;
    db_state_t     state_q;
    db_state_t     state_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic          press_stb;
    logic          rep_stb;

    // Two synchronizer flops idle released; s_q is the registered pressed level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            s_q     <= ~sync2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_q)                 state_d = IDLE;
                else if (dcnt_q == DLAST) state_d = HELD;
                else                      dcnt_d  = dcnt_q + DW'(1);
            end
            HELD: begin
                if (!s_q) begin
                    state_d = REL_WAIT;
                    dcnt_d  = '0;
                end
            end
            REL_WAIT: begin
                if (s_q)                  state_d = HELD;
                else if (dcnt_q == DLAST) state_d = IDLE;
                else                      dcnt_d  = dcnt_q + DW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // The press strobe fires in the last qualifying PRESS_WAIT cycle only
    always_comb begin
        lvl_o     = 1'b0;
        press_stb = 1'b0;
        case (state_q)
            PRESS_WAIT: press_stb = s_q && (dcnt_q == DLAST);
            HELD:       lvl_o     = 1'b1;
            REL_WAIT:   lvl_o     = 1'b1;
            default:    lvl_o     = 1'b0;
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RW = cnt_width((RDLY > RPER) ? RDLY : RPER);

    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          rep_q;
    logic          rep_d;

    // Counter idles at zero outside HELD, so every entry into HELD restarts the delay
    always_comb begin
        rcnt_d  = '0;
        rep_d   = 1'b0;
        rep_stb = 1'b0;
        if (state_q == HELD) begin
            if (rcnt_q == (rep_q ? RW'(RPER - 1) : RW'(RDLY - 1))) begin
                rep_stb = 1'b1;
                rep_d   = 1'b1;
            end else begin
                rcnt_d  = rcnt_q + RW'(1);
                rep_d   = rep_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end
`else
    assign rep_stb = 1'b0;
`endif

    assign en_o = press_stb | rep_stb;

endmodule

// File: rtl/en_pulse_gen.sv
// Enable strobe source: free-running TICK prescaler, BLINK toggle and debounced button.
// Define BTN_AUTO_REPEAT_EN to add hold-to-repeat BTN_EN strobes.
module en_pulse_gen
    import en_pulse_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned DB_MS      = 10,
    parameter int unsigned REP_DLY_MS = 500,
    parameter int unsigned REP_MS     = 100
) (
    input  logic clk,
    input  logic RST,
    input  logic RUN,
    input  logic BTN_N,
    output logic TICK,
    output logic BLINK,
    output logic BTN_LVL,
    output logic BTN_EN
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned DBC = ms_to_cycles(CLK_HZ, DB_MS);
    localparam int unsigned CW  = cnt_width(DIV);

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_div_check
        $error("en_pulse_gen: TICK_HZ must divide CLK_HZ exactly with DIV >= 2");
    end
    if (DBC < 1) begin : g_dbc_check
        $error("en_pulse_gen: debounce window must be at least one cycle");
    end
    if (REP_DLY_MS == 0 || REP_MS == 0) begin : g_rep_check
        $error("en_pulse_gen: repeat delay and period must be nonzero");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          blink_q;
    logic          blink_d;

    assign TICK  = RUN && (cnt_q == CW'(DIV - 1));
    assign BLINK = blink_q;

    // RUN low only freezes the count; the phase survives a pause
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (RUN) begin
            if (TICK) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RDLY = ms_to_cycles(CLK_HZ, REP_DLY_MS);
    localparam int unsigned RPER = ms_to_cycles(CLK_HZ, REP_MS);
`endif

    btn_debounce #(
        .DBC  (DBC)
`ifdef BTN_AUTO_REPEAT_EN
       ,.RDLY (RDLY)
       ,.RPER (RPER)
`endif
    ) u_btn_debounce (
        .clk_i   (clk),
        .rst_i   (RST),
        .btn_n_i (BTN_N),
        .lvl_o   (BTN_LVL),
        .en_o    (BTN_EN)
    );

endmodule

// File: tb/tb_en_pulse_gen.sv
// Scoreboard bench for en_pulse_gen: a run-length button model and RUN-cycle tick
// model queue expected strobes that a negedge monitor matches against the outputs.
module tb_en_pulse_gen;

    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned TICK_HZ    = 100;
    localparam int unsigned DB_MS      = 4;
    localparam int unsigned REP_DLY_MS = 20;
    localparam int unsigned REP_MS     = 10;
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int DBC  = CLK_HZ / 1000 * DB_MS;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RDLY = CLK_HZ / 1000 * REP_DLY_MS;
    localparam int RPER = CLK_HZ / 1000 * REP_MS;
`endif
    localparam int MAXC = 4096;

    logic clk   = 1'b0;
    logic RST   = 1'b1;
    logic RUN   = 1'b0;
    logic BTN_N = 1'b1;
    logic TICK;
    logic BLINK;
    logic BTN_LVL;
    logic BTN_EN;

    en_pulse_gen #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .DB_MS      (DB_MS),
        .REP_DLY_MS (REP_DLY_MS),
        .REP_MS     (REP_MS)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .RUN     (RUN),
        .BTN_N   (BTN_N),
        .TICK    (TICK),
        .BLINK   (BLINK),
        .BTN_LVL (BTN_LVL),
        .BTN_EN  (BTN_EN)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit val;
    } ev_t;

    ev_t tickQ[$];
    ev_t enQ[$];
    ev_t lvlQ[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: level flips once s has held the opposite value DBC+1 cycles
    bit inHist[MAXC];
    int rBase     = 0;
    int runCnt    = 0;
    bit mBlink    = 0;
    bit mL        = 0;
    bit flipPend  = 0;
    bit sPrev     = 0;
    int runLen    = 0;
    bit rstPrev   = 1;
    bit heldPrev  = 0;
    int heldStart = 0;

    function automatic ev_t mkEv(input int c, input bit v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs just after the edge and advance the reference model
    task automatic applyStimulus(input bit rst, input bit run, input bit btnN);
        int  n;
        bit  s;
        bit  held;
        int  k;
        @(posedge clk);
        #1;
        RST   = rst;
        RUN   = run;
        BTN_N = btnN;
        n = cyc;
        if (n < MAXC) inHist[n] = btnN;
        if (rst) begin
            rstPrev  = 1;
            flipPend = 0;
            return;
        end
        if (rstPrev) begin
            rstPrev  = 0;
            rBase    = n;
            runCnt   = 0;
            mBlink   = 0;
            if (mL) lvlQ.push_back(mkEv(n, 1'b0));
            mL       = 0;
            sPrev    = 0;
            runLen   = 0;
            heldPrev = 0;
        end else if (flipPend) begin
            flipPend = 0;
            mL = ~mL;
            lvlQ.push_back(mkEv(n, mL));
        end
        if (run) begin
            runCnt++;
            if (runCnt % DIV == 0) begin
                tickQ.push_back(mkEv(n, ~mBlink));
                mBlink = ~mBlink;
            end
        end
        s = (n - 3 >= rBase && n - 3 < MAXC) ? ~inHist[n - 3] : 1'b0;
        held = mL && sPrev;
`ifdef BTN_AUTO_REPEAT_EN
        if (held) begin
            if (!heldPrev) heldStart = n;
            k = n - heldStart + 1;
            if (k == RDLY || (k > RDLY && (k - RDLY) % RPER == 0))
                enQ.push_back(mkEv(n, 1'b1));
        end
`else
        k = 0;
`endif
        heldPrev = held;
        runLen = (s == sPrev) ? runLen + 1 : 1;
        sPrev  = s;
        if (s != mL && runLen == DBC + 1) begin
            flipPend = 1;
            if (s) enQ.push_back(mkEv(n, 1'b1));
        end
    endtask

    // Monitor: matches every TICK/BTN_EN pulse and BTN_LVL change to the queues
    initial begin : monitor
        bit lvlPrev;
        int blinkCyc;
        bit blinkExp;
        bit due;
        lvlPrev  = 0;
        blinkCyc = -10;
        blinkExp = 0;
        forever begin
            @(negedge clk);
            if (RST !== 1'b0) continue;
            while (tickQ.size() > 0 && tickQ[0].cyc < cyc) begin
                checkOutput("TICK stale", 0, 1);
                void'(tickQ.pop_front());
            end
            while (enQ.size() > 0 && enQ[0].cyc < cyc) begin
                checkOutput("BTN_EN stale", 0, 1);
                void'(enQ.pop_front());
            end
            while (lvlQ.size() > 0 && lvlQ[0].cyc < cyc) begin
                checkOutput("BTN_LVL stale", 0, 1);
                void'(lvlQ.pop_front());
            end
            if (blinkCyc == cyc - 1) checkOutput("BLINK after TICK", BLINK, blinkExp);
            due = (tickQ.size() > 0 && tickQ[0].cyc == cyc);
            if (TICK !== 1'b0 || due) begin
                checkOutput("TICK", TICK, due);
                if (due) begin
                    blinkCyc = cyc;
                    blinkExp = tickQ[0].val;
                    void'(tickQ.pop_front());
                end
            end
            due = (enQ.size() > 0 && enQ[0].cyc == cyc);
            if (BTN_EN !== 1'b0 || due) begin
                checkOutput("BTN_EN", BTN_EN, due);
                if (due) void'(enQ.pop_front());
            end
            due = (lvlQ.size() > 0 && lvlQ[0].cyc == cyc);
            if (BTN_LVL !== lvlPrev || due) begin
                checkOutput("BTN_LVL", BTN_LVL, due ? lvlQ[0].val : lvlPrev);
                if (due) void'(lvlQ.pop_front());
            end
            lvlPrev = BTN_LVL;
        end
    end

    initial begin : stimulus
        bit btn;
        int seg;
        repeat (3) applyStimulus(1, 0, 1);

        applyStimulus(0, 1, 1);
        @(negedge clk);
        checkOutput("reset TICK", TICK, 0);
        checkOutput("reset BLINK", BLINK, 0);
        checkOutput("reset BTN_LVL", BTN_LVL, 0);
        checkOutput("reset BTN_EN", BTN_EN, 0);
        repeat (34) applyStimulus(0, 1, 1);

        repeat (2) applyStimulus(1, 1, 1);
        for (int i = 1; i <= 40; i++) applyStimulus(0, !(i >= 5 && i <= 9), 1);

        repeat (20) applyStimulus(0, 1, 0);
        repeat (15) applyStimulus(0, 1, 1);

        repeat (3) applyStimulus(0, 1, 0);
        repeat (12) applyStimulus(0, 1, 1);
        @(negedge clk);
        checkOutput("glitch BTN_LVL", BTN_LVL, 0);

        repeat (5) applyStimulus(0, 1, 0);
        repeat (2) applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        @(negedge clk);
        checkOutput("mid-press reset BTN_EN", BTN_EN, 0);
        checkOutput("mid-press reset BTN_LVL", BTN_LVL, 0);
        checkOutput("mid-press reset BLINK", BLINK, 0);
        repeat (14) applyStimulus(0, 1, 0);
        repeat (12) applyStimulus(0, 1, 1);

        repeat (60) applyStimulus(0, 1, 0);
        repeat (15) applyStimulus(0, 1, 1);

        btn = 1;
        seg = 4;
        for (int i = 0; i < 800; i++) begin
            if (seg == 0) begin
                btn = ~btn;
                seg = $urandom_range(1, 14);
            end
            seg--;
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, btn);
        end

        repeat (8) applyStimulus(0, 1, 1);
        @(negedge clk);
        checkOutput("TICK queue drained", tickQ.size(), 0);
        checkOutput("BTN_EN queue drained", enQ.size(), 0);
        checkOutput("BTN_LVL queue drained", lvlQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/en_pulse_gen.md
# en_pulse_gen

Generates the single-cycle enable strobes that drive the EN inputs of the clock's enabled flip-flops and counters. A free-running prescaler produces a periodic `TICK` strobe. A synchronizer/debouncer turns a raw, bouncing, active-low push-button into a clean level and a one-cycle `BTN_EN` press strobe. It sits between the board inputs and the time/alarm register datapath, on the driving end of every EN line.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TICK_HZ`, 1: `TICK` rate. `DIV = CLK_HZ/TICK_HZ`; both must divide exactly, and `DIV` must be ≥ 2.
- `DB_MS`, 10: debounce window. `DBC = CLK_HZ/1000*DB_MS` cycles; `DBC` must be ≥ 1.
- `REP_DLY_MS`, 500: hold time before auto-repeat starts (`RDLY` cycles).
- `REP_MS`, 100: auto-repeat period (`RPER` cycles).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RUN`  in  1  prescaler count enable; low freezes the prescaler.
- `BTN_N`  in  1  raw asynchronous button, low = pressed.
- `TICK`  out  1  one-cycle strobe, once per `DIV` cycles while `RUN`=1.
- `BLINK`  out  1  toggles on every `TICK` (50 % duty display blink).
- `BTN_LVL`  out  1  debounced level, 1 = pressed.
- `BTN_EN`  out  1  one-cycle strobe per accepted press (plus repeats when enabled).

## Operation
- Prescaler `cnt` counts 0..DIV-1 while `RUN`=1 and holds its value while `RUN`=0; it is never cleared by `RUN`.
- `TICK`=1 combinationally in the cycle where `cnt`=DIV-1 and `RUN`=1; in that cycle `cnt` wraps to 0 and `BLINK` toggles on the same edge.
- `BTN_N` passes through a 2-flop synchronizer, reset value 1 (released). `s` denotes the synchronized pressed level.
- Debounce FSM, counter `dcnt`:
  - IDLE: `s`=1 → PRESS_WAIT, `dcnt`=0.
  - PRESS_WAIT: `s`=0 → IDLE. Otherwise `dcnt`++. When `dcnt`=DBC-1 → HELD, and `BTN_EN`=1 for that cycle only.
  - HELD: `BTN_LVL`=1. `s`=0 → REL_WAIT, `dcnt`=0.
  - REL_WAIT: `s`=1 → HELD. Otherwise `dcnt`++. When `dcnt`=DBC-1 → IDLE.
- `BTN_LVL`=1 in HELD and REL_WAIT; 0 otherwise.
- Bounce inside a window restarts the FSM from that window's entry state; no strobe is emitted for a rejected press.
- `TICK` and `BTN_EN` are independent and may assert in the same cycle.

## Timing
- Reset values: `TICK`=0, `BLINK`=0, `BTN_LVL`=0, `BTN_EN`=0, `cnt`=0, `dcnt`=0, FSM=IDLE, synchronizer flops=1.
- `RST` has priority over all other inputs. Asserting it mid-press drops the press with no strobe; a button still held after reset release is re-debounced from IDLE.
- First `TICK` comes DIV cycles after reset deassertion with `RUN` held high; thereafter the period is exactly DIV cycles, excluding cycles with `RUN`=0.
- `BTN_N` low sampled at edge k:
  - `s`=1 after edge k+2.
  - FSM enters PRESS_WAIT at edge k+3.
  - `BTN_EN` is high in the cycle following edge k+2+DBC.
- Release is recognized DBC cycles after `s` falls. No strobe is emitted on release.

## Configuration
- `BTN_AUTO_REPEAT_EN` defined:
  - In HELD, a repeat counter starts at entry.
  - After `RDLY` cycles, `BTN_EN` strobes once.
  - After that, `BTN_EN` strobes every `RPER` cycles until leaving HELD.
  - The counter clears on entering REL_WAIT.
  - Bounce back into HELD from REL_WAIT restarts the repeat delay.
- Macro undefined: exactly one `BTN_EN` per press. The `REP_*` parameters are ignored and the repeat counter is not built.

## Structure
- Package `en_pulse_pkg`:
  - debounce state enum `db_state_t` (IDLE, PRESS_WAIT, HELD, REL_WAIT);
  - `ms_to_cycles(clk_hz, ms)` constant function;
  - counter-width helper based on `$clog2`.
- Sub-module `btn_debounce` contains the synchronizer, FSM, and optional repeat logic. The top level holds the prescaler, `BLINK`, and one `btn_debounce` instance.

## Test plan
All scenarios use `CLK_HZ`=1000, `TICK_HZ`=100 (DIV=10), `DB_MS`=4 (DBC=4), `REP_DLY_MS`=20, `REP_MS`=10.
- Reset with `RUN`=1 for 35 cycles → `TICK` pulses at cycles 10, 20, 30 (1 cycle each); `BLINK` is 1, 0, 1 after each pulse.
- `RUN` low for cycles 5–9 → next `TICK` at cycle 15, then every 10 cycles.
- Clean press held 20 cycles at edge k → exactly one `BTN_EN` in the cycle after edge k+6; `BTN_LVL` rises with it and falls 4 cycles after the synchronized release.
- Glitch of 3 cycles low, then high → no `BTN_EN`, `BTN_LVL` stays 0, FSM back in IDLE.
- `RST` asserted 2 cycles into PRESS_WAIT, button still held → all outputs 0; a `BTN_EN` appears 7 cycles after `RST` deasserts.
- With `BTN_AUTO_REPEAT_EN`, hold for 60 cycles → initial strobe, then repeats 20 cycles after it and every 10 cycles after that (4 repeats). Without the macro → exactly one strobe.
